mesm6_gpio_port: RTL and testbench
==================================

Name: mesm6_gpio_port

Overview:
Parametrised bidirectional GPIO port for the MESM-6 peripheral bus, replacing the read-only GPIO stub. Features:
- Direction control per pin.
- Output latch with atomic set/clear/invert registers.
- Multi-stage input synchroniser.
- Per-pin rising/falling change-notify with sticky write-1-to-clear flags and a registered interrupt request to the CPU.

Parameters:
WIDTH, 48, number of pins (1..48); register data is 48 bits, upper bits read 0 and ignore writes.
SYNC_STAGES, 2, input synchroniser depth (>=2).
RESET_TRIS, all ones, reset value of TRIS (1 = input).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
interrupt  output  1  registered interrupt request to CPU
gpio_in  input  WIDTH  pad inputs from board (asynchronous)
gpio_out  output  WIDTH  pad output values (= LAT)
gpio_oe  output  WIDTH  pad output enables (= ~TRIS)
gpio_addr  input  15  register address; only bits [3:0] decoded
gpio_read  input  1  read request, single-cycle pulse
gpio_write  input  1  write request, single-cycle pulse
gpio_rdata  output  48  registered read data
gpio_wdata  input  48  write data
gpio_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync release): LAT=0, TRIS=RESET_TRIS, CNRISE=0, CNFALL=0, CNFLAG=0, CNIE=0, sync chain=0, prev=0, interrupt=0, gpio_rdata=0, gpio_done=0.
- Register map (addr[3:0], octal):
  - 00 PORT: read = synchronised pad value s (all pins, either direction); write loads LAT.
  - 01 LAT: RW.
  - 02 LATSET: write sets LAT bits where wdata=1; read = LAT.
  - 03 LATCLR: write clears LAT bits where wdata=1; read = LAT.
  - 04 LATINV: write inverts LAT bits where wdata=1; read = LAT.
  - 05 TRIS: RW.
  - 06 CNRISE: RW rising-edge enable.
  - 07 CNFALL: RW falling-edge enable.
  - 10 CNFLAG: read sticky flags; write-1-to-clear.
  - 11 CNIE: bit0 global enable; read {47'b0, CNIE}.
  - 12-17: read 0, writes ignored.
- Bus handshake:
  - Request sampled at posedge N; write effect visible at N+1.
  - gpio_rdata valid and gpio_done=1 for exactly cycle N+1.
  - gpio_rdata holds its value until the next read.
  - Read and write asserted together: write performed, rdata not updated, one done pulse.
  - Back-to-back requests every cycle are supported.
- Synchroniser: s = gpio_in delayed SYNC_STAGES clocks; prev <= s each cycle.
- Edge detection:
  - rise = s & ~prev & CNRISE.
  - fall = ~s & prev & CNFALL.
  - CNFLAG <= (CNFLAG & ~w1c) | rise | fall.
  - A new edge wins over a simultaneous W1C on the same bit.
  - Edges are detected regardless of TRIS, so output readback can trigger change-notify.
- Interrupt: interrupt <= CNIE & |CNFLAG.
  - Pad change sampled at edge N sets CNFLAG at N+SYNC_STAGES+1 and raises interrupt at N+SYNC_STAGES+2.
  - Clearing the last flag or CNIE drops interrupt one cycle after the CNFLAG/CNIE update.
- Pulses shorter than one clock may be missed. A pulse held for at least 1 clock, once through the synchroniser, sets both rise and fall flags if both are enabled.
- Mid-operation reset: all state returns to reset values immediately; a pending done pulse is lost.
- Pins >= WIDTH: LAT, TRIS, CN* bits are tied off; they read 0 (TRIS reads 0 there).

Decomposition:
- Package mesm6_gpio_pkg holds:
  - the register address localparams (REG_PORT ... REG_CNIE);
  - the 4-bit reg-select typedef;
  - the DATA_W=48 constant.
- Sub-module mesm6_sync: a parametrised N-stage async-reset synchroniser (width, stages), instantiated once for gpio_in.

Test Plan:
- Reset, then read every address 00-17 -> TRIS reads {48{1}} (WIDTH=48), all others 0; gpio_oe=0; done pulses exactly one cycle after each read.
- Write LAT='o1234, LATSET='o0003, LATCLR='o0200, LATINV='o0011 -> LAT reads 'o1026; gpio_out='o1026 one cycle after the last write.
- TRIS=0, LAT='o5 -> gpio_oe all ones; PORT reads the driven value looped back through gpio_in after SYNC_STAGES+1 cycles.
- CNRISE=1, CNIE=1, drive gpio_in[0] 0->1 at cycle N -> CNFLAG bit0 at N+3, interrupt at N+4 (SYNC_STAGES=2); write CNFLAG=1 -> interrupt low 2 cycles later.
- CNFALL=2, new falling edge on pin1 in the same cycle as a W1C of bit1 -> bit1 stays set; interrupt stays high.
- Assert reset_n low mid-read while interrupt=1 -> interrupt, gpio_done, LAT drop to 0 immediately without a clock edge.

Source files
------------

// File: rtl/mesm6_gpio_pkg.sv
// Shared constants and types for the MESM-6 bidirectional GPIO port.
// The register map is decoded from gpio_addr[3:0]; the octal map maps onto these codes.
package mesm6_gpio_pkg;

    localparam int DATA_W = 48;

    typedef logic [3:0] reg_sel_t;

    localparam reg_sel_t REG_PORT   = 4'd0;   // 00
    localparam reg_sel_t REG_LAT    = 4'd1;   // 01
    localparam reg_sel_t REG_LATSET = 4'd2;   // 02
    localparam reg_sel_t REG_LATCLR = 4'd3;   // 03
    localparam reg_sel_t REG_LATINV = 4'd4;   // 04
    localparam reg_sel_t REG_TRIS   = 4'd5;   // 05
    localparam reg_sel_t REG_CNRISE = 4'd6;   // 06
    localparam reg_sel_t REG_CNFALL = 4'd7;   // 07
    localparam reg_sel_t REG_CNFLAG = 4'd8;   // 10
    localparam reg_sel_t REG_CNIE   = 4'd9;   // 11

    // Bit mask of implemented pins; bits at and above width are tied off.
    function automatic logic [DATA_W-1:0] pin_mask(input int width);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/mesm6_sync.sv
// Parametrised N-stage synchroniser with asynchronous active-low reset.
// Output is the input delayed by STAGES clocks.
module mesm6_sync
    import mesm6_gpio_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            // NOTE: non-blocking, so each stage takes its predecessor's old value
            // and the chain really is STAGES flops deep.
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/mesm6_gpio_port.sv
// Bidirectional GPIO port: direction, output latch with atomic set/clear/invert,
// synchronised inputs and per-pin rising/falling change-notify with an interrupt.
module mesm6_gpio_port
    import mesm6_gpio_pkg::*;
#(
    parameter int                WIDTH       = 48,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_TRIS  = '1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              interrupt,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    input  logic [14:0]       gpio_addr,
    input  logic              gpio_read,
    input  logic              gpio_write,
    output logic [DATA_W-1:0] gpio_rdata,
    input  logic [DATA_W-1:0] gpio_wdata,
    output logic              gpio_done
);

    localparam logic [DATA_W-1:0] PIN_MASK = pin_mask(WIDTH);

    logic [DATA_W-1:0] lat;
    logic [DATA_W-1:0] tris;
    logic [DATA_W-1:0] cnrise;
    logic [DATA_W-1:0] cnfall;
    logic [DATA_W-1:0] cnflag;
    logic              cnie;

    logic [WIDTH-1:0]  s_pins;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] rise;
    logic [DATA_W-1:0] fall;
    logic [DATA_W-1:0] w1c;
    logic [DATA_W-1:0] lat_next;
    logic [DATA_W-1:0] rd_mux;

    reg_sel_t sel;
    logic     addr_unused;

    assign sel         = gpio_addr[3:0];
    assign addr_unused = ^gpio_addr[14:4];

    mesm6_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (gpio_in),
        .q       (s_pins)
    );

    assign s = DATA_W'(s_pins);

    // Edges are seen regardless of direction, so driven outputs can raise change-notify.
    assign rise = s & ~prev & cnrise;
    assign fall = ~s & prev & cnfall;
    assign w1c  = (gpio_write && sel == REG_CNFLAG) ? gpio_wdata : '0;

    always_comb begin
        // NOTE: default assigned first so every path drives lat_next and no latch is inferred.
        lat_next = lat;
        if (gpio_write) begin
            case (sel)
                REG_PORT,
                REG_LAT:    lat_next = gpio_wdata;
                REG_LATSET: lat_next = lat | gpio_wdata;
                REG_LATCLR: lat_next = lat & ~gpio_wdata;
                REG_LATINV: lat_next = lat ^ gpio_wdata;
                default:    lat_next = lat;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_PORT:   rd_mux = s;
            REG_LAT,
            REG_LATSET,
            REG_LATCLR,
            REG_LATINV: rd_mux = lat;
            REG_TRIS:   rd_mux = tris;
            REG_CNRISE: rd_mux = cnrise;
            REG_CNFALL: rd_mux = cnfall;
            REG_CNFLAG: rd_mux = cnflag;
            REG_CNIE:   rd_mux = {{(DATA_W-1){1'b0}}, cnie};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat        <= '0;
            tris       <= RESET_TRIS & PIN_MASK;
            cnrise     <= '0;
            cnfall     <= '0;
            cnflag     <= '0;
            cnie       <= 1'b0;
            prev       <= '0;
            interrupt  <= 1'b0;
            gpio_rdata <= '0;
            gpio_done  <= 1'b0;
        end else begin
            lat  <= lat_next & PIN_MASK;
            prev <= s;

            if (gpio_write) begin
                case (sel)
                    REG_TRIS:   tris   <= gpio_wdata & PIN_MASK;
                    REG_CNRISE: cnrise <= gpio_wdata & PIN_MASK;
                    REG_CNFALL: cnfall <= gpio_wdata & PIN_MASK;
                    REG_CNIE:   cnie   <= gpio_wdata[0];
                    default:    ;
                endcase
            end

            // A new edge wins over a simultaneous write-1-to-clear of the same bit.
            cnflag    <= ((cnflag & ~w1c) | rise | fall) & PIN_MASK;
            interrupt <= cnie & (|cnflag);

            gpio_done <= gpio_read | gpio_write;
            if (gpio_read && !gpio_write) begin
                gpio_rdata <= rd_mux;
            end
        end
    end

    assign gpio_out = lat[WIDTH-1:0];
    assign gpio_oe  = ~tris[WIDTH-1:0];

endmodule

// File: tb/tb_mesm6_gpio_port.sv
// Self-checking bench for mesm6_gpio_port: directed vector table, multi-cycle
// change-notify/reset sequences, and randomized bus traffic against a register-level model.
module tb_mesm6_gpio_port;
    import mesm6_gpio_pkg::*;

    localparam int W  = 48;
    localparam int SS = 2;
    localparam logic [47:0] ONES = {48{1'b1}};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         interrupt;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic [14:0]  gpio_addr;
    logic         gpio_read;
    logic         gpio_write;
    logic [47:0]  gpio_rdata;
    logic [47:0]  gpio_wdata;
    logic         gpio_done;

    logic [W-1:0] pad;
    logic         loop_en;

    assign gpio_in = loop_en ? gpio_out : pad;

    always #5 clk = ~clk;

    mesm6_gpio_port #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .RESET_TRIS  (ONES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .interrupt  (interrupt),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .gpio_oe    (gpio_oe),
        .gpio_addr  (gpio_addr),
        .gpio_read  (gpio_read),
        .gpio_write (gpio_write),
        .gpio_rdata (gpio_rdata),
        .gpio_wdata (gpio_wdata),
        .gpio_done  (gpio_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus request sampled at the next posedge; returns at the following negedge.
    task automatic bus(input logic rd, input logic wr, input logic [3:0] addr, input logic [47:0] wdata);
        gpio_read  = rd;
        gpio_write = wr;
        gpio_addr  = {11'd0, addr};
        gpio_wdata = wdata;
        @(negedge clk);
        gpio_read  = 1'b0;
        gpio_write = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [47:0] data);
        bus(1'b0, 1'b1, addr, data);
        check($sformatf("wr_done@%0d", addr), {47'd0, gpio_done}, 48'd1);
    endtask

    task automatic rd(input string name, input logic [3:0] addr, input logic [47:0] exp);
        bus(1'b1, 1'b0, addr, '0);
        check({name, "_done"}, {47'd0, gpio_done}, 48'd1);
        check(name, gpio_rdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [47:0] wdata;
        logic [47:0] exp_rdata;
        logic        chk_out;
        logic [47:0] exp_out;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic w, input logic [3:0] a,
                                input logic [47:0] d, input logic [47:0] e,
                                input logic co, input logic [47:0] eo);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.wdata = d;
        v.exp_rdata = e; v.chk_out = co; v.exp_out = eo;
        return v;
    endfunction

    // Register-level reference model.
    logic [47:0] m_lat, m_tris, m_rise, m_fall, m_flag, m_pad, m_rdata;
    logic        m_ie;

    function automatic logic [47:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:                   return m_pad;
            4'd1, 4'd2, 4'd3, 4'd4: return m_lat;
            4'd5:                   return m_tris;
            4'd6:                   return m_rise;
            4'd7:                   return m_fall;
            4'd8:                   return m_flag;
            4'd9:                   return {47'd0, m_ie};
            default:                return 48'd0;
        endcase
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [47:0] d);
        case (a)
            4'd0, 4'd1: m_lat  = d;
            4'd2:       m_lat  = m_lat | d;
            4'd3:       m_lat  = m_lat & ~d;
            4'd4:       m_lat  = m_lat ^ d;
            4'd5:       m_tris = d;
            4'd6:       m_rise = d;
            4'd7:       m_fall = d;
            4'd8:       m_flag = m_flag & ~d;
            4'd9:       m_ie   = d[0];
            default:    ;
        endcase
    endtask

    task automatic model_pad_change(input logic [47:0] from, input logic [47:0] to);
        m_flag = m_flag | (to & ~from & m_rise) | (~to & from & m_fall);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected to finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];

        gpio_read = 1'b0; gpio_write = 1'b0; gpio_addr = '0; gpio_wdata = '0;
        pad = '0; loop_en = 1'b0; reset_n = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_irq",   {47'd0, interrupt}, 48'd0);
        check("rst_done",  {47'd0, gpio_done}, 48'd0);
        check("rst_rdata", gpio_rdata, 48'd0);
        check("rst_oe",    gpio_oe, 48'd0);
        check("rst_out",   gpio_out, 48'd0);
        reset_n = 1'b1;
        idle(2);

        // Directed vector table.
        for (int a = 0; a < 16; a++)
            vecs.push_back(mk(1'b1, 1'b0, 4'(a), '0, (a == 5) ? ONES : 48'd0, 1'b0, '0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd1, 48'o1234, '0, 1'b0, '0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd2, 48'o0003, '0, 1'b0, '0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd3, 48'o0200, '0, 1'b0, '0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd4, 48'o0011, '0, 1'b1, 48'o1026));
        vecs.push_back(mk(1'b1, 1'b0, 4'd1, '0, 48'o1026, 1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 4'd2, '0, 48'o1026, 1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 4'd3, '0, 48'o1026, 1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 4'd4, '0, 48'o1026, 1'b0, '0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd10, 48'o777, '0, 1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 4'd10, '0, 48'd0, 1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b1, 4'd1, 48'o1026, 48'd0, 1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 4'd1, '0, 48'o1026, 1'b0, '0));

        for (int i = 0; i < vecs.size(); i++) begin
            bus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_done", i), {47'd0, gpio_done}, 48'd1);
            if (vecs[i].rd) check($sformatf("vec%0d_rdata", i), gpio_rdata, vecs[i].exp_rdata);
            if (vecs[i].chk_out) check($sformatf("vec%0d_out", i), gpio_out, vecs[i].exp_out);
        end
        @(negedge clk);
        check("done_single_pulse", {47'd0, gpio_done}, 48'd0);

        // Output drive looped back through the synchroniser.
        wr(4'd1, 48'd0);
        loop_en = 1'b1;
        wr(4'd5, 48'd0);
        check("loop_oe", gpio_oe, ONES);
        idle(4);
        wr(4'd1, 48'o5);
        rd("loop_port_e1", 4'd0, 48'd0);
        rd("loop_port_e2", 4'd0, 48'd0);
        rd("loop_port_e3", 4'd0, 48'o5);
        loop_en = 1'b0;
        wr(4'd5, ONES);
        wr(4'd1, 48'd0);
        idle(4);

        // Rising edge on pin0: flag after SS+1, interrupt one cycle later.
        wr(4'd6, 48'd1);
        wr(4'd9, 48'd1);
        idle(3);
        pad[0] = 1'b1;
        rd("cn_flag_n0", 4'd8, 48'd0);
        rd("cn_flag_n1", 4'd8, 48'd0);
        rd("cn_flag_n2", 4'd8, 48'd0);
        check("cn_irq_early", {47'd0, interrupt}, 48'd0);
        rd("cn_flag_n3", 4'd8, 48'd1);
        check("cn_irq_set", {47'd0, interrupt}, 48'd1);
        wr(4'd8, 48'd1);
        check("cn_irq_hold", {47'd0, interrupt}, 48'd1);
        idle(1);
        check("cn_irq_clear", {47'd0, interrupt}, 48'd0);
        rd("cn_flag_cleared", 4'd8, 48'd0);

        // Falling edge on pin1 coinciding with a W1C of bit1: edge wins.
        pad[1] = 1'b1;
        idle(4);
        wr(4'd7, 48'd2);
        pad[1] = 1'b0;
        idle(4);
        rd("fall_flag", 4'd8, 48'd2);
        check("fall_irq", {47'd0, interrupt}, 48'd1);
        pad[1] = 1'b1;
        idle(4);
        pad[1] = 1'b0;
        idle(2);
        wr(4'd8, 48'd2);
        check("race_irq0", {47'd0, interrupt}, 48'd1);
        idle(1);
        check("race_irq1", {47'd0, interrupt}, 48'd1);
        rd("race_flag", 4'd8, 48'd2);
        check("race_irq2", {47'd0, interrupt}, 48'd1);

        // Asynchronous reset in the middle of a read.
        wr(4'd1, 48'o77);
        gpio_read = 1'b1;
        gpio_addr = 15'd8;
        @(posedge clk);
        #2;
        check("mid_done_before", {47'd0, gpio_done}, 48'd1);
        reset_n = 1'b0;
        #1;
        check("mid_irq",   {47'd0, interrupt}, 48'd0);
        check("mid_done",  {47'd0, gpio_done}, 48'd0);
        check("mid_lat",   gpio_out, 48'd0);
        check("mid_oe",    gpio_oe, 48'd0);
        check("mid_rdata", gpio_rdata, 48'd0);
        gpio_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(4);
        rd("post_rst_tris", 4'd5, ONES);
        rd("post_rst_flag", 4'd8, 48'd0);

        // Randomized traffic against the model.
        m_lat = '0; m_tris = ONES; m_rise = '0; m_fall = '0; m_flag = '0; m_ie = 1'b0;
        m_pad = pad; m_rdata = 48'd0;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                logic [47:0] nv;
                logic [47:0] ov;
                nv = {$urandom, $urandom};
                ov = m_pad;
                pad = nv;
                if ($urandom_range(0, 1) == 1) begin
                    @(negedge clk);
                    pad = ov;
                    model_pad_change(ov, nv);
                    model_pad_change(nv, ov);
                end else begin
                    model_pad_change(ov, nv);
                    m_pad = nv;
                end
                idle(5);
                check($sformatf("rnd%0d_irq_pad", it), {47'd0, interrupt}, {47'd0, m_ie & (|m_flag)});
            end else begin
                logic [3:0]  a;
                logic [47:0] d;
                logic        r, w, exp_irq;
                int          op;
                a  = 4'($urandom_range(0, 15));
                d  = {$urandom, $urandom};
                op = $urandom_range(0, 2);
                r  = (op != 1);
                w  = (op != 0);
                exp_irq = m_ie & (|m_flag);
                if (r && !w) m_rdata = model_read(a);
                bus(r, w, a, d);
                if (w) model_write(a, d);
                check($sformatf("rnd%0d_done", it), {47'd0, gpio_done}, 48'd1);
                check($sformatf("rnd%0d_rdata@%0d", it, a), gpio_rdata, m_rdata);
                check($sformatf("rnd%0d_irq", it), {47'd0, interrupt}, {47'd0, exp_irq});
                check($sformatf("rnd%0d_out", it), gpio_out, m_lat);
            end
        end
        rd("final_flag", 4'd8, m_flag);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
